// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel edge detector: FSM encoding,
// kernel and gray-conversion weights, and the magnitude width.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int PIX_W = 8;
  localparam int MAG_W = 11;

  localparam logic signed [MAG_W-1:0] K_EDGE = 11'sd1;
  localparam logic signed [MAG_W-1:0] K_CTR  = 11'sd2;

  localparam logic [9:0] GRAY_WR    = 10'd1;
  localparam logic [9:0] GRAY_WG    = 10'd2;
  localparam logic [9:0] GRAY_WB    = 10'd1;
  localparam int         GRAY_SHIFT = 2;

endpackage

// File: rtl/sobel_line_buffer.sv
// One-row delay line of 8-bit pixels; dout is the pixel pushed DEPTH shifts ago.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 720
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [DEPTH-1:0][PIX_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (en) mem_d = {mem_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel magnitude: FWFT FIFO in, one result per input pixel out,
// borders forced to zero, FILL/RUN/FLUSH sequencing per frame.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH   = 720,
  parameter int IMG_HEIGHT  = 540,
  parameter int DWIDTH_IN   = 24,
  parameter int DWIDTH_OUT  = 8,
  parameter int MAG_SHIFT   = 0,
  parameter int THRESH_MODE = 0,
  parameter int THRESH      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                  fifo_out_full
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0]    ROW_ONE  = RW'(1);
  localparam logic [MAG_W-1:0] SAT_MAX  = MAG_W'((1 << DWIDTH_OUT) - 1);

  function automatic logic signed [MAG_W-1:0] wsum(input logic [PIX_W-1:0] a, b, c);
    return $signed({3'b0, a}) * K_EDGE + $signed({3'b0, b}) * K_CTR + $signed({3'b0, c}) * K_EDGE;
  endfunction

  function automatic logic [MAG_W-1:0] absv(input logic signed [MAG_W-1:0] g);
    return g[MAG_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

  function automatic logic [DWIDTH_OUT-1:0] scale_mag(input logic [MAG_W-1:0] m);
    logic [MAG_W-1:0] s;
    s = m >> MAG_SHIFT;
    if (THRESH_MODE != 0) return (int'(s) > THRESH) ? '1 : '0;
    return (s > SAT_MAX) ? '1 : s[DWIDTH_OUT-1:0];
  endfunction

  state_e                state_q, state_d;
  logic [CW-1:0]         in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RW-1:0]         in_row_q, in_row_d, out_row_q, out_row_d;
  logic                  out_valid_q, out_valid_d;
  logic [DWIDTH_OUT-1:0] dout_q, dout_d;
  logic [2:0][2:0][PIX_W-1:0] w_q, w_d;

  logic                    step, border;
  logic [PIX_W-1:0]        gray, pix, lb0_out, lb1_out;
  logic signed [MAG_W-1:0] gx, gy;
  logic [MAG_W-1:0]        mag;

  generate
    if (DWIDTH_IN == 24) begin : g_rgb
      logic [9:0] gray_sum;
      assign gray_sum = {2'b0, fifo_in_dout[23:16]} * GRAY_WR
                      + {2'b0, fifo_in_dout[15:8]}  * GRAY_WG
                      + {2'b0, fifo_in_dout[7:0]}   * GRAY_WB;
      assign gray = gray_sum[GRAY_SHIFT +: PIX_W];
    end else begin : g_mono
      assign gray = fifo_in_dout[PIX_W-1:0];
    end
  endgenerate

  // A step never happens while the output register is stalled; FLUSH runs without input.
  assign step = rst_n && (!out_valid_q || !fifo_out_full)
             && (state_q == ST_FLUSH || !fifo_in_empty);
  assign fifo_in_rd_en  = step && (state_q != ST_FLUSH);
  assign fifo_out_wr_en = out_valid_q && !fifo_out_full;
  assign fifo_out_din   = dout_q;
  assign pix            = (state_q == ST_FLUSH) ? '0 : gray;

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .en(step), .din(pix), .dout(lb0_out)
  );
  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .en(step), .din(lb0_out), .dout(lb1_out)
  );

  always_comb begin
    w_d = w_q;
    if (step) begin
      for (int r = 0; r < 3; r++) begin
        w_d[r][0] = w_q[r][1];
        w_d[r][1] = w_q[r][2];
      end
      w_d[0][2] = lb1_out;
      w_d[1][2] = lb0_out;
      w_d[2][2] = pix;
    end
  end

  // Result is taken from the window as it will look after this step.
  assign gx  = wsum(w_d[0][2], w_d[1][2], w_d[2][2]) - wsum(w_d[0][0], w_d[1][0], w_d[2][0]);
  assign gy  = wsum(w_d[2][0], w_d[2][1], w_d[2][2]) - wsum(w_d[0][0], w_d[0][1], w_d[0][2]);
  assign mag = absv(gx) + absv(gy);
  assign border = (out_row_q == '0) || (out_row_q == ROW_LAST)
               || (out_col_q == '0) || (out_col_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    if (fifo_out_wr_en) out_valid_d = 1'b0;
    if (step) begin
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
      // Index W (col 0, row 1) marks both the end of FILL and the W+1th flush step.
      unique case (state_q)
        ST_FILL:  if (in_col_q == '0 && in_row_q == ROW_ONE) state_d = ST_RUN;
        ST_RUN:   if (in_col_q == COL_LAST && in_row_q == ROW_LAST) state_d = ST_FLUSH;
        ST_FLUSH: if (in_col_q == '0 && in_row_q == ROW_ONE) begin
          state_d  = ST_FILL;
          in_col_d = '0;
          in_row_d = '0;
        end
        default:  state_d = ST_FILL;
      endcase
      if (state_q != ST_FILL) begin
        out_valid_d = 1'b1;
        dout_d      = border ? '0 : scale_mag(mag);
        if (out_col_q == COL_LAST) begin
          out_col_d = '0;
          out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
        end else begin
          out_col_d = out_col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      in_col_q    <= '0;
      in_row_q    <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  always_ff @(posedge clk) w_q <= w_d;

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x4 frame: four parameter variants
// share one input stream and handshake, outputs compared against a vector table.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] ea, eb, ec, ed;
  } vec_t;

  typedef struct packed {
    logic [7:0]  g;
    logic [23:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_empty = 1'b1;
  logic        out_full = 1'b0;
  logic [7:0]  in_g = '0;
  logic [23:0] in_rgb = '0;
  logic        rd_a, rd_b, rd_c, rd_d, wr_a, wr_b, wr_c, wr_d;
  logic [7:0]  dout_a, dout_b, dout_c, dout_d;

  vec_t       tbl [4][N];
  pix_t       in_q[$];
  logic [7:0] cap_a[$], cap_b[$], cap_c[$], cap_d[$];
  bit         cap_rdlow[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_IN(8), .DWIDTH_OUT(8),
                 .MAG_SHIFT(0), .THRESH_MODE(0), .THRESH(128)) u_a (
    .clk(clk), .rst_n(rst_n), .fifo_in_rd_en(rd_a), .fifo_in_dout(in_g),
    .fifo_in_empty(in_empty), .fifo_out_wr_en(wr_a), .fifo_out_din(dout_a),
    .fifo_out_full(out_full));

  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_IN(8), .DWIDTH_OUT(8),
                 .MAG_SHIFT(3), .THRESH_MODE(0), .THRESH(128)) u_b (
    .clk(clk), .rst_n(rst_n), .fifo_in_rd_en(rd_b), .fifo_in_dout(in_g),
    .fifo_in_empty(in_empty), .fifo_out_wr_en(wr_b), .fifo_out_din(dout_b),
    .fifo_out_full(out_full));

  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_IN(8), .DWIDTH_OUT(8),
                 .MAG_SHIFT(0), .THRESH_MODE(1), .THRESH(200)) u_c (
    .clk(clk), .rst_n(rst_n), .fifo_in_rd_en(rd_c), .fifo_in_dout(in_g),
    .fifo_in_empty(in_empty), .fifo_out_wr_en(wr_c), .fifo_out_din(dout_c),
    .fifo_out_full(out_full));

  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_IN(24), .DWIDTH_OUT(8),
                 .MAG_SHIFT(0), .THRESH_MODE(0), .THRESH(128)) u_d (
    .clk(clk), .rst_n(rst_n), .fifo_in_rd_en(rd_d), .fifo_in_dout(in_rgb),
    .fifo_in_empty(in_empty), .fifo_out_wr_en(wr_d), .fifo_out_din(dout_d),
    .fifo_out_full(out_full));

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic set_exp(input int p, input int idx, input logic [7:0] a, b, c, d);
    tbl[p][idx].ea = a;
    tbl[p][idx].eb = b;
    tbl[p][idx].ec = c;
    tbl[p][idx].ed = d;
  endtask

  task automatic push_frame(input int p);
    pix_t e;
    for (int i = 0; i < N; i++) begin
      e.g   = tbl[p][i].pix;
      e.rgb = (p == 0) ? 24'h4080C0 : {3{tbl[p][i].pix}};
      in_q.push_back(e);
    end
  endtask

  task automatic clear_caps();
    cap_a.delete(); cap_b.delete(); cap_c.delete(); cap_d.delete();
    cap_rdlow.delete();
  endtask

  // One clock: drive at the falling edge, observe handshakes 1ns later.
  task automatic cycle(input bit stall);
    @(negedge clk);
    in_empty = (in_q.size() == 0) || (stall && $urandom_range(0, 1) == 1);
    if (in_q.size() != 0) begin
      in_g   = in_q[0].g;
      in_rgb = in_q[0].rgb;
    end
    out_full = stall && ($urandom_range(0, 1) == 1);
    #1;
    if (rd_a !== rd_b || rd_a !== rd_c || rd_a !== rd_d ||
        wr_a !== wr_b || wr_a !== wr_c || wr_a !== wr_d) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake agreement: rd %b%b%b%b wr %b%b%b%b, expected all equal",
               rd_a, rd_b, rd_c, rd_d, wr_a, wr_b, wr_c, wr_d);
    end
    if (rd_a === 1'b1 && in_q.size() != 0) void'(in_q.pop_front());
    if (wr_a === 1'b1) begin
      cap_a.push_back(dout_a);
      cap_b.push_back(dout_b);
      cap_c.push_back(dout_c);
      cap_d.push_back(dout_d);
      cap_rdlow.push_back(rd_a !== 1'b1);
    end
  endtask

  task automatic run_expect(input int n_out, input bit stall, input string tag);
    int cyc;
    cyc = 0;
    while (cap_a.size() < n_out && cyc < 3000) begin
      cycle(stall);
      cyc++;
    end
    repeat (20) cycle(1'b0);
    n_vec++;
    if (cap_a.size() != n_out) begin
      n_err++;
      $display("FAIL %s write count: got %0d, expected %0d", tag, cap_a.size(), n_out);
    end
  endtask

  task automatic check_frame(input int base, input int p, input string tag);
    for (int i = 0; i < N; i++) begin
      if (base + i >= cap_a.size()) begin
        n_vec++;
        n_err++;
        $display("FAIL %s output %0d: got none, expected a write", tag, i);
        return;
      end
      cmp($sformatf("%s[%0d].a", tag, i), cap_a[base+i], tbl[p][i].ea);
      cmp($sformatf("%s[%0d].b", tag, i), cap_b[base+i], tbl[p][i].eb);
      cmp($sformatf("%s[%0d].c", tag, i), cap_c[base+i], tbl[p][i].ec);
      cmp($sformatf("%s[%0d].d", tag, i), cap_d[base+i], tbl[p][i].ed);
    end
  endtask

  initial begin
    int lowcnt;
    // Pattern 0 uniform 0x80, 1 vertical edge, 2 horizontal edge, 3 single dot.
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < N; i++) begin
        tbl[p][i].pix = 8'h00;
        set_exp(p, i, 8'd0, 8'd0, 8'd0, 8'd0);
      end
    for (int i = 0; i < N; i++) begin
      tbl[0][i].pix = 8'h80;
      tbl[1][i].pix = (i % W >= 4) ? 8'hFF : 8'h00;
      tbl[2][i].pix = (i >= 16) ? 8'hFF : 8'h00;
    end
    tbl[3][10].pix = 8'h10;
    foreach (tbl[1][i]) if (i == 11 || i == 12 || i == 19 || i == 20)
      set_exp(1, i, 8'd255, 8'd127, 8'd255, 8'd255);
    for (int c = 1; c <= 6; c++) begin
      set_exp(2, 8 + c, 8'd255, 8'd127, 8'd255, 8'd255);
      set_exp(2, 16 + c, 8'd255, 8'd127, 8'd255, 8'd255);
    end
    set_exp(3, 9,  8'd32, 8'd4, 8'd0, 8'd32);
    set_exp(3, 11, 8'd32, 8'd4, 8'd0, 8'd32);
    set_exp(3, 17, 8'd32, 8'd4, 8'd0, 8'd32);
    set_exp(3, 18, 8'd32, 8'd4, 8'd0, 8'd32);
    set_exp(3, 19, 8'd32, 8'd4, 8'd0, 8'd32);

    // Reset state with data presented at the input.
    in_empty = 1'b0;
    in_g     = 8'h55;
    #3;
    cmp("reset rd_en", {7'd0, rd_a}, 8'd0);
    cmp("reset wr_en", {7'd0, wr_a}, 8'd0);
    cmp("reset din", dout_a, 8'd0);
    in_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    push_frame(0);
    run_expect(N, 1'b0, "uniform");
    check_frame(0, 0, "uniform");
    lowcnt = 0;
    if (cap_rdlow.size() >= N)
      for (int i = N - 9; i < N; i++) lowcnt += int'(cap_rdlow[i]);
    cmp("uniform flush writes rd_en low", 8'(lowcnt), 8'd9);
    clear_caps();

    for (int p = 1; p < 4; p++) begin
      push_frame(p);
      run_expect(N, 1'b0, $sformatf("pat%0d", p));
      check_frame(0, p, $sformatf("pat%0d", p));
      clear_caps();
    end

    push_frame(1);
    run_expect(N, 1'b1, "stall_vedge");
    check_frame(0, 1, "stall_vedge");
    clear_caps();
    push_frame(3);
    run_expect(N, 1'b1, "stall_dot");
    check_frame(0, 3, "stall_dot");
    clear_caps();
    push_frame(0);
    run_expect(N, 1'b1, "stall_uniform");
    check_frame(0, 0, "stall_uniform");
    clear_caps();

    push_frame(1);
    push_frame(3);
    run_expect(2 * N, 1'b0, "b2b");
    check_frame(0, 1, "b2b_f0");
    check_frame(N, 3, "b2b_f1");
    clear_caps();

    // Reset in the middle of RUN, then a clean frame.
    push_frame(2);
    repeat (20) cycle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("midrun reset rd_en", {7'd0, rd_a}, 8'd0);
    cmp("midrun reset wr_en", {7'd0, wr_a}, 8'd0);
    cmp("midrun reset din", dout_a, 8'd0);
    in_empty = 1'b1;
    in_q.delete();
    clear_caps();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(3);
    run_expect(N, 1'b0, "post_reset");
    check_frame(0, 3, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
